sram_mem_ctrl: RTL and testbench

Initiator side of the external SRAM bus: accepts single-word load/store requests from the MEM stage and drives `SRAM_WE_N`/`SRAM_ADDR`/`SRAM_DQ` toward the SRAM model. The SRAM runs on a half-rate clock and needs several CPU cycles per access, so the block holds the access for a fixed number of cycles. It deasserts `ready` so the pipeline freezes until the access completes. It sits between the MEM stage and the top-level SRAM pins of `ARM`.

---
 rtl/arm_mem_pkg.sv | 8 +
 rtl/sram_mem_ctrl.sv | 64 ++++++
 tb/tb_sram_mem_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/arm_mem_pkg.sv
// arm_mem_pkg: shared SRAM bus types, widths and default address map
package arm_mem_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} sram_state_t;
  localparam int SRAM_ADDR_W = 17;
  localparam int SRAM_DATA_W = 64;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] DEF_BASE_ADDR = 32'd1024;
endpackage

// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl: holds one MEM-stage load/store on the SRAM bus for a fixed cycle count
module sram_mem_ctrl
  import arm_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 4,
  parameter logic [WORD_W-1:0] BASE_ADDR = DEF_BASE_ADDR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [WORD_W-1:0]      addr,
  input  logic [WORD_W-1:0]      wdata,
  output logic [WORD_W-1:0]      rdata,
  output logic                   ready,
  output logic                   SRAM_WE_N,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ
);
  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);
  sram_state_t state;
  logic [3:0] wait_cnt;
  logic op_wr;
  logic [SRAM_ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic drive;
  // Request latch, access timer and read capture; inputs matter only at the accept edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      rdata    <= '0;
      op_wr    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      case (state)
        IDLE: if (wr_en | rd_en) begin
          op_wr    <= wr_en;
          addr_q   <= SRAM_ADDR_W'((addr - BASE_ADDR) >> 2);
          wdata_q  <= wdata;
          wait_cnt <= '0;
          state    <= ACCESS;
        end
        ACCESS: begin
          wait_cnt <= wait_cnt + 4'd1;
          if (wait_cnt == LAST) begin
            if (!op_wr) rdata <= WORD_W'(SRAM_DQ);
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  // Bus is driven only while a write is in flight; ready drops in the request cycle itself
  always_comb begin
    drive     = state == ACCESS && op_wr;
    ready     = state == DONE || (state == IDLE && !(wr_en | rd_en));
    SRAM_WE_N = !drive;
    SRAM_ADDR = state == ACCESS ? addr_q : '0;
  end
  assign SRAM_DQ = drive ? {{(SRAM_DATA_W-WORD_W){1'b0}}, wdata_q} : 'z;
endmodule

// File: tb/tb_sram_mem_ctrl.sv
// tb_sram_mem_ctrl: scoreboard bench for the SRAM access controller with a behavioural SRAM
module tb_sram_mem_ctrl;
  import arm_mem_pkg::*;
  localparam int W = 4;
  localparam logic [31:0] PAT = 32'hCAFEF00D;

  logic clk = 1'b0, rst = 1'b0, wr_en = 1'b0, rd_en = 1'b0, model_clr = 1'b1;
  logic [31:0] addr = '0, wdata = '0;
  wire [31:0] rdata;
  wire ready, sram_we_n;
  wire [16:0] sram_addr;
  wire [63:0] dq;

  sram_mem_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(32'd1024)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .SRAM_WE_N(sram_we_n), .SRAM_ADDR(sram_addr), .SRAM_DQ(dq)
  );

  always #5 clk = ~clk;

  // SRAM model: small hashed store; drives a tagged word whenever the controller is not writing
  logic [31:0] mem [0:63];
  wire [5:0] slot = {sram_addr[16], sram_addr[4:0]};
  assign dq = sram_we_n ? {PAT, mem[slot]} : 'z;
  always @(posedge clk) begin
    if (model_clr) for (int i = 0; i < 64; i++) mem[i] <= '0;
    else if (!sram_we_n) mem[slot] <= dq[31:0];
  end

  typedef struct {
    logic        wr;
    logic [16:0] sa;
    logic [31:0] wd;
    logic [31:0] rd;
  } exp_t;
  exp_t sb[$];
  exp_t got;
  logic [31:0] shadow [logic [16:0]];
  logic [31:0] exp_rdata = '0;
  int n_cmp = 0, n_bad = 0;
  int lo, nwe, nbus, nrd_bad;
  bit req_ready;

  function automatic logic [31:0] shadow_rd(logic [16:0] k);
    return shadow.exists(k) ? shadow[k] : 32'h0;
  endfunction

  task automatic push(bit w, logic [16:0] sa, logic [31:0] d);
    exp_t e;
    e.wr = w; e.sa = sa; e.wd = d;
    if (w) shadow[sa] = d;
    else exp_rdata = shadow_rd(sa);
    e.rd = exp_rdata;
    sb.push_back(e);
  endtask

  task automatic run_access(bit w, bit r, logic [31:0] a, logic [31:0] d, logic [16:0] sa);
    bit tmo = 1'b1;
    push(w, sa, d);
    @(negedge clk);
    wr_en = w; rd_en = r; addr = a; wdata = d;
    #1;
    req_ready = ready;
    lo = ready ? 0 : 1; nwe = 0; nbus = 0; nrd_bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      wr_en = 1'($urandom_range(0, 1)); rd_en = 1'($urandom_range(0, 1));
      addr = $urandom; wdata = $urandom;
      #1;
      if (ready) begin
        wr_en = 1'b0; rd_en = 1'b0;
        tmo = 1'b0;
        break;
      end
      lo++;
      if (!sram_we_n) nwe++;
      if (!sram_we_n && sram_addr === sa && dq === {32'h0, d}) nbus++;
      if (sram_we_n && (sram_addr !== sa || dq !== {PAT, mem[slot]})) nrd_bad++;
    end
    n_cmp++;
    if (tmo) begin
      n_bad++;
      $display("FAIL timeout: ready stayed 0 for 40 cycles, wanted 1 after %0d", W + 1);
    end
    got = sb.pop_front();
  endtask

  task automatic test_reset();
    rst = 1'b0; model_clr = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", ready); end
    n_cmp++; if (sram_we_n !== 1'b1) begin n_bad++; $display("FAIL reset_we_n got %b want 1", sram_we_n); end
    n_cmp++; if (sram_addr !== 17'h0) begin n_bad++; $display("FAIL reset_addr got %h want 0", sram_addr); end
    n_cmp++; if (dq !== {PAT, 32'h0}) begin n_bad++; $display("FAIL reset_dq got %h want %h", dq, {PAT, 32'h0}); end
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got %h want 0", rdata); end
    rst = 1'b1; model_clr = 1'b0;
  endtask

  task automatic test_write();
    run_access(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 17'd1);
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL wr_req_ready got %b want 0", req_ready); end
    n_cmp++; if (lo !== W + 1) begin n_bad++; $display("FAIL wr_stall got %0d want %0d", lo, W + 1); end
    n_cmp++; if (nwe !== W) begin n_bad++; $display("FAIL wr_strobe_cycles got %0d want %0d", nwe, W); end
    n_cmp++; if (nbus !== W) begin n_bad++; $display("FAIL wr_bus_cycles got %0d want %0d", nbus, W); end
    n_cmp++; if (sram_we_n !== 1'b1 || sram_addr !== 17'h0) begin n_bad++; $display("FAIL wr_done_bus got we_n=%b addr=%h want 1/0", sram_we_n, sram_addr); end
    n_cmp++; if (rdata !== got.rd) begin n_bad++; $display("FAIL wr_rdata got %h want %h", rdata, got.rd); end
  endtask

  task automatic test_read();
    run_access(1'b0, 1'b1, 32'd1028, $urandom, 17'd1);
    n_cmp++; if (lo !== W + 1) begin n_bad++; $display("FAIL rd_stall got %0d want %0d", lo, W + 1); end
    n_cmp++; if (nwe !== 0) begin n_bad++; $display("FAIL rd_strobe got %0d want 0", nwe); end
    n_cmp++; if (nrd_bad !== 0) begin n_bad++; $display("FAIL rd_bus got %0d bad cycles want 0", nrd_bad); end
    n_cmp++; if (rdata !== got.rd) begin n_bad++; $display("FAIL rd_data got %h want %h", rdata, got.rd); end
    @(negedge clk); #1;
    n_cmp++; if (rdata !== got.rd) begin n_bad++; $display("FAIL rd_hold got %h want %h", rdata, got.rd); end
  endtask

  task automatic test_both();
    run_access(1'b1, 1'b1, 32'd1032, 32'h12345678, 17'd2);
    n_cmp++; if (nbus !== W) begin n_bad++; $display("FAIL both_write got %0d want %0d", nbus, W); end
    n_cmp++; if (rdata !== got.rd) begin n_bad++; $display("FAIL both_rdata got %h want %h", rdata, got.rd); end
  endtask

  task automatic test_wrap();
    run_access(1'b1, 1'b0, 32'h2, 32'h5A5A1234, 17'h1FF00);
    n_cmp++; if (nbus !== W) begin n_bad++; $display("FAIL wrap_write got %0d want %0d", nbus, W); end
    run_access(1'b0, 1'b1, 32'h3, 32'h0, 17'h1FF00);
    n_cmp++; if (rdata !== got.rd) begin n_bad++; $display("FAIL wrap_read got %h want %h", rdata, got.rd); end
  endtask

  task automatic test_back_to_back();
    run_access(1'b0, 1'b1, 32'd1024, 32'h0, 17'd0);
    n_cmp++; if (rdata !== got.rd) begin n_bad++; $display("FAIL b2b_read got %h want %h", rdata, got.rd); end
    run_access(1'b1, 1'b0, 32'd1036, 32'hA1B2C3D4, 17'd3);
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_bubble got %b want 0", req_ready); end
    n_cmp++; if (lo !== W + 1) begin n_bad++; $display("FAIL b2b_stall got %0d want %0d", lo, W + 1); end
    n_cmp++; if (nbus !== W) begin n_bad++; $display("FAIL b2b_write got %0d want %0d", nbus, W); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    wr_en = 1'b1; addr = 32'd1040; wdata = 32'h11112222;
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++; if (sram_we_n !== 1'b0 || sram_addr !== 17'd4) begin n_bad++; $display("FAIL mid_access got we_n=%b addr=%h want 0/4", sram_we_n, sram_addr); end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_rdata = '0;
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready got %b want 1", ready); end
    n_cmp++; if (sram_we_n !== 1'b1) begin n_bad++; $display("FAIL mid_we_n got %b want 1", sram_we_n); end
    n_cmp++; if (dq !== {PAT, mem[slot]}) begin n_bad++; $display("FAIL mid_dq got %h want %h", dq, {PAT, mem[slot]}); end
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL mid_rdata got %h want 0", rdata); end
    run_access(1'b0, 1'b1, 32'd1024, 32'h0, 17'd0);
    n_cmp++; if (lo !== W + 1) begin n_bad++; $display("FAIL mid_read_stall got %0d want %0d", lo, W + 1); end
    n_cmp++; if (rdata !== got.rd) begin n_bad++; $display("FAIL mid_read got %h want %h", rdata, got.rd); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_both();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
